palette_color_encoder: RTL and testbench



---
 rtl/palette_color_encoder.sv | 137 +++++++++++++
 tb/tb_palette_color_encoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/palette_color_encoder.sv
// rtl/palette_color_encoder.sv - nearest-entry RGB to palette index encoder, one entry scanned per clock
// Optional: define EXACT_MATCH_EARLY_EXIT_EN to end the scan on the first zero-distance entry.
module palette_color_encoder #(
  parameter int ENTRIES = 16,
  parameter int CW      = 4,
  parameter int IDX_W   = 4,
  parameter int DIST_W  = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_red,
  input  logic [CW-1:0]     in_green,
  input  logic [CW-1:0]     in_blue,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DIST_W-1:0] out_dist,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_addr,
  input  logic [3*CW-1:0]   pal_rgb,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state, state_nxt;
  logic [3*CW-1:0]   pal [ENTRIES];
  logic [CW-1:0]     req_r, req_g, req_b;
  logic [IDX_W-1:0]  ptr, best_idx;
  logic [DIST_W-1:0] best_dist, d;
  logic [3*CW-1:0]   pal_cur;
  logic              accept, last, hit, scan_end, better;

  function automatic logic [3*CW-1:0] default_entry(input int i);
    logic [11:0] e;
    case (i)
      0:  e = 12'hFE8;
      1:  e = 12'hC25;
      2:  e = 12'h982;
      3:  e = 12'h501;
      4:  e = 12'hDA3;
      5:  e = 12'hD17;
      6:  e = 12'h760;
      7:  e = 12'hEA4;
      8:  e = 12'hFDB;
      9:  e = 12'hA35;
      10: e = 12'hB82;
      11: e = 12'h852;
      12: e = 12'hF99;
      13: e = 12'hEC6;
      14: e = 12'h970;
      default: e = 12'hC66;
    endcase
    return (3*CW)'(e);
  endfunction

  function automatic logic [DIST_W-1:0] sq_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW-1:0]   ad;
    logic [2*CW-1:0] sq;
    ad = (a > b) ? (a - b) : (b - a);
    sq = {{CW{1'b0}}, ad} * {{CW{1'b0}}, ad};
    return DIST_W'(sq);
  endfunction

  assign pal_cur = pal[ptr];
  assign d = sq_diff(req_r, pal_cur[3*CW-1:2*CW])
           + sq_diff(req_g, pal_cur[2*CW-1:CW])
           + sq_diff(req_b, pal_cur[CW-1:0]);
  assign better   = (d < best_dist);
  assign last     = (ptr == IDX_W'(ENTRIES - 1));
`ifdef EXACT_MATCH_EARLY_EXIT_EN
  assign hit      = (d == '0);
`else
  assign hit      = 1'b0;
`endif
  assign scan_end = last || hit;
  assign accept   = (state == IDLE) && in_valid;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SCAN;
      SCAN:    if (scan_end)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Palette is a register array, so a write on the accept edge is already visible to the entry-0 read.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < ENTRIES; i++) pal[i] <= default_entry(i);
      req_r     <= '0;
      req_g     <= '0;
      req_b     <= '0;
      ptr       <= '0;
      best_idx  <= '0;
      best_dist <= '1;
      out_index <= '0;
      out_dist  <= '0;
    end else begin
      if ((state == IDLE) && pal_we) pal[pal_addr] <= pal_rgb;
      if (accept) begin
        req_r     <= in_red;
        req_g     <= in_green;
        req_b     <= in_blue;
        ptr       <= '0;
        best_idx  <= '0;
        best_dist <= '1;
      end else if (state == SCAN) begin
        ptr <= ptr + 1'b1;
        if (better) begin
          best_dist <= d;
          best_idx  <= ptr;
        end
        if (scan_end) begin
          out_index <= better ? ptr : best_idx;
          out_dist  <= better ? d   : best_dist;
        end
      end
    end
  end

endmodule

// File: tb/tb_palette_color_encoder.sv
// tb/tb_palette_color_encoder.sv - directed self-checking bench for palette_color_encoder
module tb_palette_color_encoder;

`ifdef EXACT_MATCH_EARLY_EXIT_EN
  localparam int LAT_HIT0 = 1;
`else
  localparam int LAT_HIT0 = 16;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_red = '0, in_green = '0, in_blue = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_index;
  logic [9:0]  out_dist;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = '0;
  logic [11:0] pal_rgb = '0;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int lat;

  palette_color_encoder dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_dist(out_dist),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_rgb(pal_rgb),
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_result(output int l);
    l = 0;
    while (!out_valid && l < 40) begin
      @(posedge Clk); #1;
      l++;
    end
  endtask

  task automatic request(input logic [11:0] rgb, output int l);
    @(negedge Clk);
    check("in_ready_before_req", in_ready, 1);
    in_valid = 1'b1;
    {in_red, in_green, in_blue} = rgb;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    wait_result(l);
  endtask

  task automatic release_result();
    @(negedge Clk);
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    check("out_valid_cleared", out_valid, 0);
    check("in_ready_after_release", in_ready, 1);
  endtask

  task automatic pal_write(input logic [3:0] a, input logic [11:0] rgb);
    @(negedge Clk);
    pal_we = 1'b1; pal_addr = a; pal_rgb = rgb;
    @(posedge Clk); #1;
    pal_we = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_dist", out_dist, 0);
    check("rst_busy", busy, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    request(12'hFE8, lat);
    check("fe8_latency", lat, LAT_HIT0);
    check("fe8_index", out_index, 0);
    check("fe8_dist", out_dist, 0);
    release_result();

    request(12'h000, lat);
    check("000_latency", lat, 16);
    check("000_index", out_index, 3);
    check("000_dist", out_dist, 26);
    release_result();

    pal_write(4'd2, 12'h898);
    pal_write(4'd5, 12'h878);
    request(12'h888, lat);
    check("888_tie_latency", lat, 16);
    check("888_tie_index", out_index, 2);
    check("888_tie_dist", out_dist, 1);
    release_result();

    request(12'h501, lat);
    check("501_valid", out_valid, 1);
    check("501_index", out_index, 3);
    check("501_dist", out_dist, 0);
    @(negedge Clk);
    in_valid = 1'b1;
    {in_red, in_green, in_blue} = 12'hFE8;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_index", out_index, 3);
      check("hold_dist", out_dist, 0);
      check("hold_in_ready", in_ready, 0);
    end
    @(negedge Clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    check("hold_cleared", out_valid, 0);
    check("hold_idle_ready", in_ready, 1);

    @(negedge Clk);
    in_valid = 1'b1;
    {in_red, in_green, in_blue} = 12'h888;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    check("midscan_busy", busy, 1);
    pal_we = 1'b1; pal_addr = 4'd0; pal_rgb = 12'h000;
    @(posedge Clk); #1;
    pal_we = 1'b0;
    wait_result(lat);
    check("midscan_done", out_valid, 1);
    release_result();
    request(12'h000, lat);
    check("dropped_write_index", out_index, 3);
    check("dropped_write_dist", out_dist, 26);
    release_result();

    @(negedge Clk);
    pal_we = 1'b1; pal_addr = 4'd0; pal_rgb = 12'h888;
    in_valid = 1'b1;
    {in_red, in_green, in_blue} = 12'h888;
    @(posedge Clk); #1;
    pal_we = 1'b0;
    in_valid = 1'b0;
    wait_result(lat);
    check("wt_latency", lat, LAT_HIT0);
    check("wt_index", out_index, 0);
    check("wt_dist", out_dist, 0);
    release_result();

    @(negedge Clk);
    in_valid = 1'b1;
    {in_red, in_green, in_blue} = 12'h000;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_out_index", out_index, 0);
    check("arst_out_dist", out_dist, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    request(12'hFE8, lat);
    check("post_rst_fe8_index", out_index, 0);
    check("post_rst_fe8_dist", out_dist, 0);
    release_result();

    request(12'h888, lat);
    check("post_rst_888_latency", lat, 16);
    check("post_rst_888_index", out_index, 15);
    check("post_rst_888_dist", out_dist, 24);
    release_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
